// File: rtl/dm1_5_reg_pkg.sv
// Shared constants for the 1-to-5 registered write distributor.
// Slot indices name the destinations of the one-hot load vector.
package dm1_5_reg_pkg;
  localparam int DATA_W   = 16;
  localparam int NUM_DEST = 5;
  localparam int SEL_W    = 3;

  localparam logic [SEL_W-1:0] SLOT0 = 3'd0;
  localparam logic [SEL_W-1:0] SLOT1 = 3'd1;
  localparam logic [SEL_W-1:0] SLOT2 = 3'd2;
  localparam logic [SEL_W-1:0] SLOT3 = 3'd3;
  localparam logic [SEL_W-1:0] SLOT4 = 3'd4;
endpackage

// File: rtl/dm1_5_reg_slot.sv
// One holding register with its VALID/ACK handshake and sticky overwrite flag.
// A load in the same cycle as an ack treats the old data as consumed.
module dm_slot
  import dm1_5_reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              ack,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              valid,
  output logic              ovf
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
      // Unconsumed data is being replaced: newest wins, but remember the loss.
      if (valid && !ack) ovf <= 1'b1;
    end else if (ack) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dm1_5_reg.sv
// Registered 1-to-5 write distributor: decodes S into a one-hot load vector
// gated by WE and a legal select, and flags illegal-select writes in ERR.
module dm1_5_reg
  import dm1_5_reg_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [DATA_W-1:0]   D,
  input  logic [SEL_W-1:0]    S,
  input  logic                WE,
  input  logic [NUM_DEST-1:0] ACK,
  input  logic                ERR_CLR,
  output logic [DATA_W-1:0]   O0,
  output logic [DATA_W-1:0]   O1,
  output logic [DATA_W-1:0]   O2,
  output logic [DATA_W-1:0]   O3,
  output logic [DATA_W-1:0]   O4,
  output logic [NUM_DEST-1:0] VALID,
  output logic [NUM_DEST-1:0] OVF,
  output logic                ERR
);

  logic                legal;
  logic [NUM_DEST-1:0] load;
  logic [DATA_W-1:0]   q [NUM_DEST];

  always_comb begin
    legal = (S <= SLOT4);
    load  = '0;
    if (WE && legal) begin
      for (int k = 0; k < NUM_DEST; k++) begin
        load[k] = (S == SEL_W'(k));
      end
    end
  end

  for (genvar k = 0; k < NUM_DEST; k++) begin : g_slot
    dm_slot u_slot (
      .clk   (CLK),
      .rst_n (RESET_N),
      .load  (load[k]),
      .ack   (ACK[k]),
      .d     (D),
      .q     (q[k]),
      .valid (VALID[k]),
      .ovf   (OVF[k])
    );
  end

  assign O0 = q[SLOT0];
  assign O1 = q[SLOT1];
  assign O2 = q[SLOT2];
  assign O3 = q[SLOT3];
  assign O4 = q[SLOT4];

  // An illegal write in the same cycle as ERR_CLR keeps ERR set.
  always_ff @(posedge CLK) begin
    if (!RESET_N)             ERR <= 1'b0;
    else if (WE && !legal)    ERR <= 1'b1;
    else if (ERR_CLR)         ERR <= 1'b0;
  end

endmodule

// File: tb/tb_dm1_5_reg.sv
// Bench for dm1_5_reg: directed scenarios plus randomized traffic
// compared against a slot-array reference model.
module tb_dm1_5_reg;
  import dm1_5_reg_pkg::*;

  logic                CLK = 1'b0;
  logic                RESET_N;
  logic [DATA_W-1:0]   D;
  logic [SEL_W-1:0]    S;
  logic                WE;
  logic [NUM_DEST-1:0] ACK;
  logic                ERR_CLR;
  logic [DATA_W-1:0]   O0, O1, O2, O3, O4;
  logic [NUM_DEST-1:0] VALID, OVF;
  logic                ERR;

  int tests = 0;
  int fails = 0;

  // Reference state: what each destination holds according to the rules.
  logic [DATA_W-1:0] m_data [NUM_DEST];
  bit                m_full [NUM_DEST];
  bit                m_lost [NUM_DEST];
  bit                m_err;

  always #5 CLK = ~CLK;

  dm1_5_reg dut (
    .CLK(CLK), .RESET_N(RESET_N), .D(D), .S(S), .WE(WE), .ACK(ACK),
    .ERR_CLR(ERR_CLR), .O0(O0), .O1(O1), .O2(O2), .O3(O3), .O4(O4),
    .VALID(VALID), .OVF(OVF), .ERR(ERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] dut_o(input int k);
    case (k)
      0: return O0;
      1: return O1;
      2: return O2;
      3: return O3;
      default: return O4;
    endcase
  endfunction

  task automatic model_update();
    int dst;
    if (!RESET_N) begin
      for (int k = 0; k < NUM_DEST; k++) begin
        m_data[k] = '0; m_full[k] = 0; m_lost[k] = 0;
      end
      m_err = 0;
      return;
    end
    dst = int'(S);
    if (WE && dst >= NUM_DEST) m_err = 1;
    else if (ERR_CLR)          m_err = 0;
    for (int k = 0; k < NUM_DEST; k++) begin
      if (WE && dst == k) begin
        if (m_full[k] && !ACK[k]) m_lost[k] = 1;
        m_data[k] = D;
        m_full[k] = 1;
      end else if (ACK[k]) begin
        m_full[k] = 0;
      end
    end
  endtask

  task automatic check_model();
    logic [NUM_DEST-1:0] ev, eo;
    for (int k = 0; k < NUM_DEST; k++) begin
      chk($sformatf("O%0d", k), 32'(dut_o(k)), 32'(m_data[k]));
      ev[k] = m_full[k];
      eo[k] = m_lost[k];
    end
    chk("VALID", 32'(VALID), 32'(ev));
    chk("OVF", 32'(OVF), 32'(eo));
    chk("ERR", 32'(ERR), 32'(m_err));
  endtask

  // Apply one cycle of inputs, advance the model, and compare after the edge.
  task automatic cyc(input bit rn, input bit we, input logic [SEL_W-1:0] s,
                     input logic [DATA_W-1:0] d, input logic [NUM_DEST-1:0] ack,
                     input bit clr);
    RESET_N = rn; WE = we; S = s; D = d; ACK = ack; ERR_CLR = clr;
    @(posedge CLK);
    model_update();
    #1;
    check_model();
  endtask

  initial begin
    RESET_N = 0; WE = 0; S = 0; D = 0; ACK = 0; ERR_CLR = 0;
    for (int k = 0; k < NUM_DEST; k++) begin
      m_data[k] = 'x; m_full[k] = 0; m_lost[k] = 0;
    end
    m_err = 0;
    @(negedge CLK);

    // Reset held with a write pending.
    cyc(0, 1, 3'd0, 16'hFFFF, '0, 0);
    cyc(0, 1, 3'd0, 16'hFFFF, '0, 0);
    chk("rst_O0", 32'(O0), 32'h0);
    chk("rst_VALID", 32'(VALID), 32'h0);
    chk("rst_ERR", 32'(ERR), 32'h0);

    // Basic write then ACK.
    cyc(1, 1, 3'd2, 16'hA5A5, '0, 0);
    chk("wr_O2", 32'(O2), 32'hA5A5);
    chk("wr_VALID", 32'(VALID), 32'b00100);
    cyc(1, 0, 3'd0, 16'h0, 5'b00100, 0);
    chk("ack_VALID", 32'(VALID), 32'h0);
    chk("ack_O2", 32'(O2), 32'hA5A5);

    // Overwrite without ACK.
    cyc(1, 1, 3'd4, 16'h1234, '0, 0);
    cyc(1, 1, 3'd4, 16'h5678, '0, 0);
    chk("ovw_O4", 32'(O4), 32'h5678);
    chk("ovw_VALID4", 32'(VALID[4]), 32'h1);
    chk("ovw_OVF", 32'(OVF), 32'b10000);

    // Write and ACK to the same slot.
    cyc(1, 1, 3'd1, 16'h1111, '0, 0);
    cyc(1, 1, 3'd1, 16'h0F0F, 5'b00010, 0);
    chk("wa_O1", 32'(O1), 32'h0F0F);
    chk("wa_VALID1", 32'(VALID[1]), 32'h1);
    chk("wa_OVF1", 32'(OVF[1]), 32'h0);

    // Illegal select, clear collision, then clear alone.
    cyc(1, 1, 3'd6, 16'hDEAD, '0, 0);
    chk("ill_ERR", 32'(ERR), 32'h1);
    chk("ill_VALID", 32'(VALID), 32'b10010);
    chk("ill_O1", 32'(O1), 32'h0F0F);
    cyc(1, 1, 3'd7, 16'hBEEF, '0, 1);
    chk("clrset_ERR", 32'(ERR), 32'h1);
    cyc(1, 0, 3'd7, 16'h0, '0, 1);
    chk("clr_ERR", 32'(ERR), 32'h0);

    // Reset mid-stream, then a normal write.
    cyc(1, 1, 3'd0, 16'h0001, '0, 0);
    cyc(1, 1, 3'd3, 16'h0003, '0, 0);
    chk("pre_O3", 32'(O3), 32'h0003);
    cyc(0, 1, 3'd1, 16'h7777, '0, 0);
    chk("mrst_O0", 32'(O0), 32'h0);
    chk("mrst_O3", 32'(O3), 32'h0);
    chk("mrst_VALID", 32'(VALID), 32'h0);
    chk("mrst_OVF", 32'(OVF), 32'h0);
    cyc(1, 1, 3'd2, 16'h0042, '0, 0);
    chk("post_O2", 32'(O2), 32'h0042);
    chk("post_VALID", 32'(VALID), 32'b00100);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [NUM_DEST-1:0] a;
      a = NUM_DEST'($urandom) & NUM_DEST'($urandom);
      cyc(($urandom_range(0, 39) != 0), $urandom_range(0, 1),
          SEL_W'($urandom_range(0, 7)), DATA_W'($urandom), a,
          ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
